// File: rtl/stony_readout_seq.sv
// Stonyman readout sequencer: pulses resp/incp/resv/incv to walk a ROWS x COLS window, one ADC req/ack per pixel (optional STONY_AMP_EN adds an inphi pulse before each settle).
// Latency: SETTLE_CYC clocks after each column pulse's low phase to adc_req; adc_req holds until adc_ack, no timeout; start is ignored while busy.
module stony_readout_seq #(
  parameter int ROWS       = 112,
  parameter int COLS       = 112,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 8,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          CLK50,
  input  logic          RESET,
  input  logic          start,
  input  logic          adc_ack,
  output logic          busy,
  output logic          frame_done,
  output logic          adc_req,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          resp,
  output logic          incp,
  output logic          resv,
  output logic          incv,
  output logic          inphi
);

  localparam int CNT_MAX = (2 * PULSE_CYC > SETTLE_CYC) ? 2 * PULSE_CYC : SETTLE_CYC;
  localparam int TW      = $clog2(CNT_MAX + 1);

  localparam logic [TW-1:0] HI_LEN      = TW'(PULSE_CYC);
  localparam logic [TW-1:0] PULSE_LAST  = TW'(2 * PULSE_CYC - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);

  typedef enum logic [3:0] {
    IDLE, F_RESP, F_INCP, F_RESV, C_RESP, C_RESV, SETTLE, REQ,
    C_INCV, R_RESP, R_INCP, R_INCV, DONE
`ifdef STONY_AMP_EN
    , AMP
`endif
  } state_t;

  // Column pulses hand over to the amplifier arm pulse when it is built in.
`ifdef STONY_AMP_EN
  localparam state_t POST_COL = AMP;
  logic amp_pin;
`else
  localparam state_t POST_COL = SETTLE;
`endif

  state_t        state_q, state_d, nxt;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          timed, adv, pin_hi, pulse_end;

  always_ff @(posedge CLK50) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    nxt       = state_q;
    timed     = 1'b0;
    adv       = 1'b0;
    resp      = 1'b0;
    incp      = 1'b0;
    resv      = 1'b0;
    incv      = 1'b0;
`ifdef STONY_AMP_EN
    amp_pin   = 1'b0;
`endif
    pin_hi    = (cnt_q < HI_LEN);
    pulse_end = (cnt_q == PULSE_LAST);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = F_RESP;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      F_RESP: begin timed = 1'b1; resp = pin_hi; adv = pulse_end; nxt = F_INCP; end
      F_INCP: begin timed = 1'b1; incp = pin_hi; adv = pulse_end; nxt = F_RESV; end
      F_RESV: begin timed = 1'b1; resv = pin_hi; adv = pulse_end; nxt = C_RESP; end
      C_RESP: begin timed = 1'b1; resp = pin_hi; adv = pulse_end; nxt = C_RESV; end
      C_RESV: begin
        timed = 1'b1; resv = pin_hi; adv = pulse_end; nxt = POST_COL;
        if (pulse_end) col_d = '0;
      end
      C_INCV: begin
        timed = 1'b1; incv = pin_hi; adv = pulse_end; nxt = POST_COL;
        if (pulse_end) col_d = col_q + 1'b1;
      end
`ifdef STONY_AMP_EN
      AMP: begin timed = 1'b1; amp_pin = pin_hi; adv = pulse_end; nxt = SETTLE; end
`endif
      SETTLE: begin timed = 1'b1; adv = (cnt_q == SETTLE_LAST); nxt = REQ; end
      REQ: begin
        // Only an ack sampled while the request is up ends it.
        if (adc_ack) begin
          if (col_q != COL_LAST)      state_d = C_INCV;
          else if (row_q != ROW_LAST) state_d = R_RESP;
          else                        state_d = DONE;
        end
      end
      R_RESP: begin timed = 1'b1; resp = pin_hi; adv = pulse_end; nxt = R_INCP; end
      R_INCP: begin timed = 1'b1; incp = pin_hi; adv = pulse_end; nxt = R_INCV; end
      R_INCV: begin
        timed = 1'b1; incv = pin_hi; adv = pulse_end; nxt = C_RESP;
        if (pulse_end) row_d = row_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (timed) begin
      cnt_d = adv ? '0 : cnt_q + 1'b1;
      if (adv) state_d = nxt;
    end
  end

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign frame_done = (state_q == DONE);
  assign adc_req    = (state_q == REQ);
  assign row        = row_q;
  assign col        = col_q;
`ifdef STONY_AMP_EN
  assign inphi      = amp_pin;
`else
  assign inphi      = 1'b0;
`endif

endmodule
